// File: rtl/period_timer.sv
// Programmable period timer with prescaler, periodic/one-shot modes, pause control,
// a wrap pulse and a saturating wrap counter. Period is shadowed and reloaded at each wrap.
module period_timer #(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  stop_in,
  input  logic                  pause_in,
  input  logic                  oneshot_in,
  input  logic [WIDTH-1:0]      period_in,
  input  logic [PRESCALE_W-1:0] prescale_in,
  output logic [WIDTH-1:0]      count_out,
  output logic                  tick_out,
  output logic                  done_out,
  output logic                  busy_out,
  output logic [WIDTH-1:0]      wrap_count_out
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      period_q, period_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  mode_q, mode_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      wrap_q, wrap_d;
  logic                  tick_q, tick_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic                  counting;
  logic                  advance;
  logic                  at_end;
  logic                  wrap_evt;

  // A zero period behaves as a period of one count.
  function automatic logic [WIDTH-1:0] period_floor(input logic [WIDTH-1:0] p);
    return (p == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : p;
  endfunction

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // period_q is never 0, so period_q-1 cannot underflow and the all-ones period works.
  assign counting = (state_q != IDLE) && !pause_in;
  assign advance  = counting && (pre_cnt_q == pre_q);
  assign at_end   = (count_q == period_q - 1'b1);
  assign wrap_evt = advance && at_end;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_in) begin
      state_d = RUN;
    end else if (stop_in) begin
      state_d = IDLE;
    end else if (state_q != IDLE) begin
      if (pause_in) begin
        state_d = PAUSED;
      end else if (wrap_evt && mode_q) begin
        state_d = IDLE;
      end else begin
        state_d = RUN;
      end
    end
  end

  always_comb begin
    period_d  = period_q;
    pre_d     = pre_q;
    mode_d    = mode_q;
    pre_cnt_d = pre_cnt_q;
    count_d   = count_q;
    wrap_d    = wrap_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    busy_d    = (state_d != IDLE);
    if (start_in) begin
      period_d  = period_floor(period_in);
      pre_d     = prescale_in;
      mode_d    = oneshot_in;
      pre_cnt_d = '0;
      count_d   = '0;
      wrap_d    = '0;
    end else if (stop_in) begin
      pre_cnt_d = '0;
      count_d   = '0;
    end else if (counting) begin
      if (advance) begin
        pre_cnt_d = '0;
        if (at_end) begin
          count_d = '0;
          tick_d  = 1'b1;
          wrap_d  = sat_inc(wrap_q);
          if (mode_q) begin
            done_d = 1'b1;
          end else begin
            period_d = period_floor(period_in);
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      period_q  <= '0;
      pre_q     <= '0;
      mode_q    <= 1'b0;
      pre_cnt_q <= '0;
      count_q   <= '0;
      wrap_q    <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      period_q  <= period_d;
      pre_q     <= pre_d;
      mode_q    <= mode_d;
      pre_cnt_q <= pre_cnt_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign count_out      = count_q;
  assign tick_out       = tick_q;
  assign done_out       = done_q;
  assign busy_out       = busy_q;
  assign wrap_count_out = wrap_q;

endmodule
